legv8_ram_waitstate: RTL

Parametrised, memory-mapped LEGv8 data RAM with a request/ready handshake and a configurable number of wait states. It replaces the single-cycle RAM detect block on the datapath bus. The block decodes its own address window and supports byte, half, word and double-word little-endian accesses. It reports misaligned or oversize accesses with an error flag instead of corrupting memory. Read data comes out on a split bus with an enable, so the datapath wrapper can drive its tristate data bus from it.

---
 rtl/legv8_ram_waitstate_if.sv | 28 ++
 rtl/legv8_ram_waitstate.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/legv8_ram_waitstate_if.sv
// Datapath-side bus for the wait-stated LEGv8 data RAM: request, write data,
// and the split read-data/enable response the wrapper uses to drive its tristate bus.
interface legv8_ram_waitstate_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_BUS_WIDTH = 32
);
  logic [ADDR_BUS_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0]     wdata;
  logic                      req;
  logic                      MW;
  logic [1:0]                size;
  logic [DATA_WIDTH-1:0]     rdata;
  logic                      rdata_en;
  logic                      ready;
  logic                      err;
  logic                      busy;
  logic                      selected;

  modport master (
    output address, wdata, req, MW, size,
    input  rdata, rdata_en, ready, err, busy, selected
  );

  modport slave (
    input  address, wdata, req, MW, size,
    output rdata, rdata_en, ready, err, busy, selected
  );
endinterface

// File: rtl/legv8_ram_waitstate.sv
// Memory-mapped LEGv8 data RAM with a req/ready handshake and WAIT_STATES extra cycles.
// Byte/half/word/dword little-endian accesses; misaligned or oversize accesses complete with err.
module legv8_ram_waitstate #(
  parameter int                        DATA_WIDTH     = 64,
  parameter int                        ADDR_BUS_WIDTH = 32,
  parameter logic [ADDR_BUS_WIDTH-1:0] BASE_ADDR      = 32'h60000000,
  parameter int                        ADDR_WIDTH     = 12,
  parameter int                        WAIT_STATES    = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  legv8_ram_waitstate_if.slave bus
);
  localparam int NB        = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(NB);
  localparam int ROWS      = (1 << ADDR_WIDTH) / NB;
  localparam logic [ADDR_WIDTH:0] SPAN = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                  state_reg;
  logic [3:0]              cnt_reg;
  logic [ADDR_WIDTH-1:0]   off_reg;
  logic [DATA_WIDTH-1:0]   wdata_reg;
  logic [1:0]              size_reg;
  logic                    mw_reg;
  logic                    ready_reg;
  logic                    err_reg;
  logic                    busy_reg;
  logic                    rdata_en_reg;
  logic [LANE_BITS-1:0]    lane_base_reg;
  logic [NB-1:0]           lane_en_reg;

  logic [3:0]                      n_bytes;
  logic [ADDR_WIDTH:0]             end_off;
  logic                            access_err;
  logic                            execute;
  logic [LANE_BITS-1:0]            lane_base;
  logic [ADDR_WIDTH-LANE_BITS-1:0] row;
  logic [NB-1:0]                   lane_hit;
  logic [DATA_WIDTH-1:0]           wdata_lane;
  logic [DATA_WIDTH-1:0]           rd_bytes;

  assign bus.selected = (bus.address[ADDR_BUS_WIDTH-1:ADDR_WIDTH] ==
                         BASE_ADDR[ADDR_BUS_WIDTH-1:ADDR_WIDTH]);

  assign n_bytes    = 4'd1 << size_reg;
  assign end_off    = {1'b0, off_reg} + (ADDR_WIDTH+1)'(n_bytes);
  assign access_err = (n_bytes > 4'(NB)) ||
                      ((off_reg[2:0] & 3'(n_bytes - 4'd1)) != 3'd0) ||
                      (end_off > SPAN);
  assign execute    = (state_reg == S_WAIT) && (cnt_reg == 4'd0);

  // Storage is banked by byte lane: an aligned access never spans two rows.
  assign lane_base  = off_reg[LANE_BITS-1:0];
  assign row        = off_reg[ADDR_WIDTH-1:LANE_BITS];
  assign wdata_lane = wdata_reg << {lane_base, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bank
      logic [7:0] bank [ROWS];
      logic [7:0] bank_q;
      logic       bank_we;
      logic       bank_re;

      assign lane_hit[gi] = (int'(lane_base) <= gi) && (gi < int'(lane_base) + int'(n_bytes));
      assign bank_we      = execute && mw_reg && !access_err && lane_hit[gi];
      assign bank_re      = execute && !mw_reg && !access_err && lane_hit[gi];

      always_ff @(posedge clock) begin
        if (bank_we) begin
          bank[row] <= wdata_lane[gi*8 +: 8];
        end
        if (bank_re) begin
          bank_q <= bank[row];
        end
      end

      // Unaccessed lanes read as zero so the shifted result is zero-extended.
      assign rd_bytes[gi*8 +: 8] = lane_en_reg[gi] ? bank_q : 8'h00;
    end
  endgenerate

  assign bus.rdata    = rd_bytes >> {lane_base_reg, 3'b000};
  assign bus.rdata_en = rdata_en_reg;
  assign bus.ready    = ready_reg;
  assign bus.err      = err_reg;
  assign bus.busy     = busy_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= 4'd0;
      off_reg       <= '0;
      wdata_reg     <= '0;
      size_reg      <= 2'b00;
      mw_reg        <= 1'b0;
      ready_reg     <= 1'b0;
      err_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      rdata_en_reg  <= 1'b0;
      lane_base_reg <= '0;
      lane_en_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.req && bus.selected) begin
            off_reg   <= bus.address[ADDR_WIDTH-1:0];
            wdata_reg <= bus.wdata;
            size_reg  <= bus.size;
            mw_reg    <= bus.MW;
            cnt_reg   <= 4'(WAIT_STATES);
            busy_reg  <= 1'b1;
            state_reg <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
          end else begin
            state_reg     <= S_DONE;
            ready_reg     <= 1'b1;
            err_reg       <= access_err;
            rdata_en_reg  <= !mw_reg;
            lane_base_reg <= lane_base;
            lane_en_reg   <= (mw_reg || access_err) ? '0 : lane_hit;
          end
        end
        S_DONE: begin
          state_reg    <= S_IDLE;
          ready_reg    <= 1'b0;
          err_reg      <= 1'b0;
          rdata_en_reg <= 1'b0;
          busy_reg     <= 1'b0;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end
endmodule
